// File: rtl/mxu_tile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mxu_tile_pkg
// Brief    : Shared FSM state type and feed-length helper for the MXU tile.
// Revision : 1.0 - initial release
// ============================================================================
package mxu_tile_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FEED = 2'd2,
        DONE = 2'd3
    } state_t;

    // Skewed operands need 3*SIZE-2 cycles to fully sweep the array.
    function automatic int feed_cycles(input int size);
        return 3 * size - 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mxu_tile_if.sv
`default_nettype none
// ============================================================================
// Module   : mxu_tile_if
// Brief    : Start/done handshake, operand bus and result read port of the tile.
// Revision : 1.0 - initial release
// ============================================================================
interface mxu_tile_if #(
    parameter int SIZE   = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
);
    localparam int ADDR_W = $clog2(SIZE * SIZE) + 1;

    logic                          start_in;
    logic                          acc_in;
    logic [SIZE*SIZE*DATA_W-1:0]   data_a_in;
    logic [SIZE*SIZE*DATA_W-1:0]   data_b_in;
    logic                          busy_o;
    logic                          done_o;
    logic [ADDR_W-1:0]             rd_addr;
    logic [ACC_W-1:0]              rd_data;

    modport master (
        output start_in, acc_in, data_a_in, data_b_in, rd_addr,
        input  busy_o, done_o, rd_data
    );

    modport slave (
        input  start_in, acc_in, data_a_in, data_b_in, rd_addr,
        output busy_o, done_o, rd_data
    );

endinterface
`default_nettype wire

// File: rtl/mxu_tile_pe.sv
`default_nettype none
// ============================================================================
// Module   : mxu_pe
// Brief    : Systolic PE: registered a/b pass-through plus multiply-accumulate.
// Revision : 1.0 - initial release
// ============================================================================
module mxu_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int SIGNED = 0
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              en,
    input  wire logic              flush,
    input  wire logic              clr_acc,
    input  wire logic [DATA_W-1:0] west_a,
    input  wire logic [DATA_W-1:0] north_b,
    output logic      [DATA_W-1:0] east_a,
    output logic      [DATA_W-1:0] south_b,
    output logic      [ACC_W-1:0]  acc
);
    localparam int c_prod_w = 2 * DATA_W;

    logic [c_prod_w-1:0] w_a_ext;
    logic [c_prod_w-1:0] w_b_ext;
    logic [c_prod_w-1:0] w_prod;
    logic [ACC_W-1:0]    w_prod_ext;

    // Operands are pre-extended so the low 2*DATA_W product bits are exact either way.
    generate
        if (SIGNED != 0) begin : g_signed
            assign w_a_ext    = {{DATA_W{west_a[DATA_W-1]}}, west_a};
            assign w_b_ext    = {{DATA_W{north_b[DATA_W-1]}}, north_b};
            assign w_prod_ext = {{(ACC_W-c_prod_w){w_prod[c_prod_w-1]}}, w_prod};
        end else begin : g_unsigned
            assign w_a_ext    = {{DATA_W{1'b0}}, west_a};
            assign w_b_ext    = {{DATA_W{1'b0}}, north_b};
            assign w_prod_ext = {{(ACC_W-c_prod_w){1'b0}}, w_prod};
        end
    endgenerate

    assign w_prod = w_a_ext * w_b_ext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            east_a  <= '0;
            south_b <= '0;
            acc     <= '0;
        end else if (flush) begin
            east_a  <= '0;
            south_b <= '0;
            if (clr_acc) begin
                acc <= '0;
            end
        end else if (en) begin
            east_a  <= west_a;
            south_b <= north_b;
            acc     <= acc + w_prod_ext;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mxu_tile.sv
`default_nettype none
// ============================================================================
// Module   : mxu_tile
// Brief    : SIZE x SIZE output-stationary systolic matrix-multiply tile.
// Revision : 1.0 - initial release
// ============================================================================
module mxu_tile
    import mxu_tile_pkg::*;
#(
    parameter int SIZE   = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int SIGNED = 0
) (
    input  wire logic  clk,
    input  wire logic  reset,
    mxu_tile_if.slave  bus
);
    localparam int ADDR_W   = $clog2(SIZE * SIZE) + 1;
    localparam int c_n_pe   = SIZE * SIZE;
    localparam int c_mat_w  = c_n_pe * DATA_W;
    localparam int c_cnt_w  = $clog2(3 * SIZE);
    localparam logic [c_cnt_w-1:0] c_last_t = c_cnt_w'(feed_cycles(SIZE) - 1);

    state_t               r_state;
    state_t               w_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_mat_w-1:0]   r_a;
    logic [c_mat_w-1:0]   r_b;
    logic                 r_acc_mode;
    logic [ACC_W-1:0]     r_rd_data;
    logic [ACC_W-1:0]     w_rd_data;
    logic                 w_busy;
    logic                 w_done;
    logic                 w_load;
    logic                 w_feed;
    logic                 w_clr;
    logic                 w_unused_spill;

    logic [DATA_W-1:0]    w_west    [SIZE];
    logic [DATA_W-1:0]    w_north   [SIZE];
    logic [DATA_W-1:0]    w_a_pipe  [SIZE][SIZE];
    logic [DATA_W-1:0]    w_b_pipe  [SIZE][SIZE];
    logic [ACC_W-1:0]     w_acc     [c_n_pe];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        w_load = 1'b0;
        w_feed = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start_in) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                w_busy = 1'b1;
                w_load = 1'b1;
                w_next = FEED;
            end
            FEED: begin
                w_busy = 1'b1;
                w_feed = 1'b1;
                if (r_cnt == c_last_t) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_clr = w_load & ~r_acc_mode;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_acc_mode <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_data <= w_rd_data;
            if (r_state == IDLE && bus.start_in) begin
                r_a        <= bus.data_a_in;
                r_b        <= bus.data_b_in;
                r_acc_mode <= bus.acc_in;
            end
            if (w_load) begin
                r_cnt <= '0;
            end else if (w_feed) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    // Diagonal skew: row r sees A(r,t-r), column c sees B(t-c,c), zero outside the window.
    always_comb begin
        for (int r = 0; r < SIZE; r++) begin
            w_west[r]  = '0;
            w_north[r] = '0;
            for (int k = 0; k < SIZE; k++) begin
                if (r_cnt == c_cnt_w'(r + k)) begin
                    w_west[r]  = r_a[(r*SIZE+k)*DATA_W +: DATA_W];
                    w_north[r] = r_b[(k*SIZE+r)*DATA_W +: DATA_W];
                end
            end
        end
    end

    generate
        for (genvar r = 0; r < SIZE; r++) begin : g_row
            for (genvar c = 0; c < SIZE; c++) begin : g_col
                logic [DATA_W-1:0] w_a_in;
                logic [DATA_W-1:0] w_b_in;

                if (c == 0) begin : g_west_edge
                    assign w_a_in = w_west[r];
                end else begin : g_west_link
                    assign w_a_in = w_a_pipe[r][c-1];
                end

                if (r == 0) begin : g_north_edge
                    assign w_b_in = w_north[c];
                end else begin : g_north_link
                    assign w_b_in = w_b_pipe[r-1][c];
                end

                mxu_pe #(
                    .DATA_W (DATA_W),
                    .ACC_W  (ACC_W),
                    .SIGNED (SIGNED)
                ) u_pe (
                    .clk     (clk),
                    .reset   (reset),
                    .en      (w_feed),
                    .flush   (w_load),
                    .clr_acc (w_clr),
                    .west_a  (w_a_in),
                    .north_b (w_b_in),
                    .east_a  (w_a_pipe[r][c]),
                    .south_b (w_b_pipe[r][c]),
                    .acc     (w_acc[r*SIZE+c])
                );
            end
        end
    endgenerate

    // Operands leaving the east and south borders have no consumer.
    always_comb begin
        w_unused_spill = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            w_unused_spill = w_unused_spill ^ (^w_a_pipe[i][SIZE-1]) ^ (^w_b_pipe[SIZE-1][i]);
        end
    end

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < c_n_pe; i++) begin
            if (bus.rd_addr == ADDR_W'(i)) begin
                w_rd_data = w_acc[i];
            end
        end
    end

    assign bus.busy_o  = w_busy;
    assign bus.done_o  = w_done;
    assign bus.rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_mxu_tile.sv
`default_nettype none
// ============================================================================
// Module   : tb_mxu_tile
// Brief    : Directed table-driven bench for unsigned and signed 4x4 MXU tiles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mxu_tile;
    localparam int SIZE   = 4;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;
    localparam int ADDR_W = 5;
    localparam int N      = 16;
    localparam int LAT    = 12;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              start;
    logic              acc_mode;
    logic [127:0]      da;
    logic [127:0]      db;
    logic [ADDR_W-1:0] ra;

    mxu_tile_if #(.SIZE(SIZE), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus_u ();
    mxu_tile_if #(.SIZE(SIZE), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus_s ();

    assign bus_u.start_in  = start;
    assign bus_u.acc_in    = acc_mode;
    assign bus_u.data_a_in = da;
    assign bus_u.data_b_in = db;
    assign bus_u.rd_addr   = ra;
    assign bus_s.start_in  = start;
    assign bus_s.acc_in    = acc_mode;
    assign bus_s.data_a_in = da;
    assign bus_s.data_b_in = db;
    assign bus_s.rd_addr   = ra;

    mxu_tile #(.SIZE(SIZE), .DATA_W(DATA_W), .ACC_W(ACC_W), .SIGNED(0)) u_dut_u (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_u)
    );

    mxu_tile #(.SIZE(SIZE), .DATA_W(DATA_W), .ACC_W(ACC_W), .SIGNED(1)) u_dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    typedef struct {
        string        name;
        logic [127:0] a;
        logic [127:0] b;
        logic         acc;
        logic [511:0] exp_u;
        logic [511:0] exp_s;
    } vec_t;

    vec_t vecs [7];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // kind: 1 identity, 2 ramp r*4+c+1, 3 ones, 4 all 0xFF, 5 all 0x02
    function automatic logic [127:0] mat(input int kind);
        logic [127:0] m;
        m = '0;
        for (int i = 0; i < N; i++) begin
            case (kind)
                1: m[i*8 +: 8] = (i / 4 == i % 4) ? 8'd1 : 8'd0;
                2: m[i*8 +: 8] = 8'(i + 1);
                3: m[i*8 +: 8] = 8'd1;
                4: m[i*8 +: 8] = 8'hFF;
                5: m[i*8 +: 8] = 8'h02;
                default: m[i*8 +: 8] = 8'd0;
            endcase
        end
        return m;
    endfunction

    function automatic logic [511:0] splat(input logic [31:0] v);
        logic [511:0] e;
        for (int i = 0; i < N; i++) e[i*32 +: 32] = v;
        return e;
    endfunction

    task automatic run(input logic [127:0] a_m, input logic [127:0] b_m, input logic acc, output int lat);
        @(negedge clk);
        da = a_m; db = b_m; acc_mode = acc; start = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start    = 1'b0;
                da       = {$urandom, $urandom, $urandom, $urandom};
                db       = {$urandom, $urandom, $urandom, $urandom};
                acc_mode = 1'($urandom);
                check("busy_cycle1", 32'(bus_u.busy_o), 32'd1);
            end
            if (bus_u.done_o) begin
                lat = n;
                check("busy_at_done", 32'(bus_u.busy_o), 32'd0);
                break;
            end
        end
    endtask

    task automatic rd(input int addr, output logic [31:0] du, output logic [31:0] ds);
        ra = ADDR_W'(addr);
        @(posedge clk);
        @(negedge clk);
        du = bus_u.rd_data;
        ds = bus_s.rd_data;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] e0, e3, e4;
        logic [31:0]  du, ds;
        int           lat, seen, first, second, cnt;

        for (int i = 0; i < N; i++) begin
            e0[i*32 +: 32] = 32'(i + 1);
            e3[i*32 +: 32] = 32'(4 * (i % 4) + 28);
            e4[i*32 +: 32] = 32'(16 * (i / 4) + 10);
        end
        vecs[0] = '{name:"ident_x_ramp",  a:mat(1), b:mat(2), acc:1'b0, exp_u:e0, exp_s:e0};
        vecs[1] = '{name:"ones_x_ones",   a:mat(3), b:mat(3), acc:1'b0, exp_u:splat(32'd4), exp_s:splat(32'd4)};
        vecs[2] = '{name:"ones_acc",      a:mat(3), b:mat(3), acc:1'b1, exp_u:splat(32'd8), exp_s:splat(32'd8)};
        vecs[3] = '{name:"ones_x_ramp",   a:mat(3), b:mat(2), acc:1'b0, exp_u:e3, exp_s:e3};
        vecs[4] = '{name:"ramp_x_ones",   a:mat(2), b:mat(3), acc:1'b0, exp_u:e4, exp_s:e4};
        vecs[5] = '{name:"ff_x_ff",       a:mat(4), b:mat(4), acc:1'b0, exp_u:splat(32'h0003F804), exp_s:splat(32'd4)};
        vecs[6] = '{name:"ff_x_02",       a:mat(4), b:mat(5), acc:1'b0, exp_u:splat(32'h000007F8), exp_s:splat(32'hFFFFFFF8)};

        reset = 1'b0; start = 1'b0; acc_mode = 1'b0; da = '0; db = '0; ra = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",   32'(bus_u.busy_o), 32'd0);
        check("rst_done",   32'(bus_u.done_o), 32'd0);
        check("rst_rdata",  bus_u.rd_data, 32'd0);
        check("rst_rdata_s", bus_s.rd_data, 32'd0);
        reset = 1'b1;
        rd(0, du, ds);  check("post_rst_c0", du, 32'd0);
        rd(15, du, ds); check("post_rst_c15", du, 32'd0);

        for (int v = 0; v < 7; v++) begin
            run(vecs[v].a, vecs[v].b, vecs[v].acc, lat);
            check($sformatf("%s_latency", vecs[v].name), 32'(lat), 32'(LAT));
            @(negedge clk);
            check($sformatf("%s_done_pulse", vecs[v].name), 32'(bus_u.done_o), 32'd0);
            for (int i = 0; i < N; i++) begin
                rd(i, du, ds);
                check($sformatf("%s_u[%0d]", vecs[v].name, i), du, vecs[v].exp_u[i*32 +: 32]);
                check($sformatf("%s_s[%0d]", vecs[v].name, i), ds, vecs[v].exp_s[i*32 +: 32]);
            end
        end

        rd(16, du, ds); check("oob16_u", du, 32'd0); check("oob16_s", ds, 32'd0);
        rd(31, du, ds); check("oob31_u", du, 32'd0); check("oob31_s", ds, 32'd0);
        ra = '0;
        @(posedge clk);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check($sformatf("idle_hold_u_%0d", n), bus_u.rd_data, 32'h000007F8);
            check($sformatf("idle_hold_s_%0d", n), bus_s.rd_data, 32'hFFFFFFF8);
        end

        // start held for 20 edges: second acceptance waits for DONE to return to IDLE
        da = mat(3); db = mat(3); acc_mode = 1'b0;
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        first = 0; second = 0; cnt = 0;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (n == 20) start = 1'b0;
            if (bus_u.done_o) begin
                cnt++;
                if (cnt == 1) first = n;
                else if (cnt == 2) second = n;
            end
        end
        check("held_first_done",  32'(first),  32'd12);
        check("held_second_done", 32'(second), 32'd25);
        check("held_done_count",  32'(cnt),    32'd2);
        rd(5, du, ds); check("held_result_c5", du, 32'd4);

        // reset during FEED cycle t=5 (7th cycle after acceptance)
        da = mat(2); db = mat(3); acc_mode = 1'b0;
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        check("midfeed_busy_before", 32'(bus_u.busy_o), 32'd1);
        reset = 1'b0;
        #1;
        check("midfeed_busy_now",  32'(bus_u.busy_o), 32'd0);
        check("midfeed_done_now",  32'(bus_u.done_o), 32'd0);
        check("midfeed_rdata_now", bus_u.rd_data, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus_u.done_o || bus_s.done_o) seen++;
        end
        check("midfeed_no_done", 32'(seen), 32'd0);
        for (int i = 0; i < N; i++) begin
            rd(i, du, ds);
            check($sformatf("midfeed_clr_u[%0d]", i), du, 32'd0);
            check($sformatf("midfeed_clr_s[%0d]", i), ds, 32'd0);
        end
        run(mat(2), mat(3), 1'b0, lat);
        check("rerun_latency", 32'(lat), 32'(LAT));
        for (int i = 0; i < N; i++) begin
            rd(i, du, ds);
            check($sformatf("rerun_u[%0d]", i), du, e4[i*32 +: 32]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mxu_tile.md
MXU_TILE -- requirements
Module: mxu_tile

Interface
- REQ-001 SHALL have parameter SIZE, default 4: array dimension (SIZE x SIZE PEs), legal 2..16.
- REQ-002 SHALL have parameter DATA_W, default 8: operand element width.
- REQ-003 SHALL have parameter ACC_W, default 32: accumulator and result width, legal >= 2*DATA_W + clog2(SIZE).
- REQ-004 SHALL have parameter SIGNED, default 0: 1 = two's-complement operands and products, 0 = unsigned.
- REQ-005 SHALL have localparam ADDR_W = clog2(SIZE*SIZE)+1.
- REQ-006 clk  input  1  sole clock, rising edge.
- REQ-007 reset  input  1  asynchronous, active-low reset.
- REQ-008 start_in  input  1  request to run one matrix product.
- REQ-009 acc_in  input  1  sampled with start: 1 = add to existing results, 0 = clear first.
- REQ-010 data_a_in  input  SIZE*SIZE*DATA_W  matrix A, element (r,c) at bits [(r*SIZE+c)*DATA_W +: DATA_W].
- REQ-011 data_b_in  input  SIZE*SIZE*DATA_W  matrix B, same packing as A.
- REQ-012 busy_o  output  1  high from the cycle after start acceptance until done_o.
- REQ-013 done_o  output  1  one-cycle completion pulse.
- REQ-014 rd_addr  input  ADDR_W  result index r*SIZE+c.
- REQ-015 rd_data  output  ACC_W  result C(r,c), registered.

Function
- REQ-016 FSM states SHALL be IDLE, LOAD, FEED, DONE.
- REQ-017 IDLE: start_in=1 at a rising edge SHALL capture data_a_in, data_b_in and acc_in into internal registers and move to LOAD.
- REQ-018 LOAD (1 cycle): if captured acc_in=0, all accumulators SHALL be cleared; feed counter SHALL be set to 0; next state FEED.
- REQ-019 FEED SHALL last exactly 3*SIZE-2 cycles, counter t = 0..3*SIZE-3; then DONE.
- REQ-020 During FEED, row r of the array SHALL receive A(r,t-r) on its west edge when 0 <= t-r < SIZE, else 0; column c SHALL receive B(t-c,c) on its north edge when 0 <= t-c < SIZE, else 0.
- REQ-021 Each PE SHALL register its a and b operands and pass them east and south, and accumulate acc += a*b each FEED cycle; PE updates SHALL occur only in FEED.
- REQ-022 Product SHALL be sign- or zero-extended per SIGNED to ACC_W; accumulation SHALL wrap modulo 2^ACC_W, with no saturation.
- REQ-023 DONE (1 cycle): done_o=1, busy_o=0; next state IDLE; start_in in DONE SHALL be ignored.
- REQ-024 Start-to-done latency: done_o SHALL be high exactly 3*SIZE cycles after the accepting edge.
- REQ-025 start_in while busy SHALL be ignored, with no queuing; operand inputs SHALL be don't-care after capture.
- REQ-026 rd_data SHALL equal C(rd_addr) one cycle after rd_addr is presented, in any state; rd_addr >= SIZE*SIZE SHALL return 0.
- REQ-027 Results SHALL hold unchanged in IDLE indefinitely; reads during FEED SHALL return partial sums without error.
- REQ-028 C after completion SHALL equal A x B, or previous C + A x B when acc_in=1.

Reset
- REQ-029 Asserting reset (low) SHALL immediately force state IDLE, busy_o=0, done_o=0, rd_data=0, all accumulators and pipeline registers 0, and feed counter 0.
- REQ-030 Reset mid-FEED SHALL abandon the operation with no done_o; the first start after deassertion SHALL behave normally.

Structure
- REQ-031 Package mxu_tile_pkg SHALL hold the state enum typedef and a function feed_cycles(SIZE) = 3*SIZE-2.
- REQ-032 One sub-module mxu_pe (registered a/b pass-through plus accumulator, parameterised DATA_W/ACC_W/SIGNED) SHALL be instantiated SIZE*SIZE times via generate.

Verification
- REQ-033 SIZE=4, A=identity, B(r,c)=r*4+c+1, acc_in=0 -> rd_data(i)=i+1 for i=0..15; done_o exactly 12 cycles after start.
- REQ-034 SIGNED=1, A all 0xFF, B all 0x02 -> every rd_data = 0xFFFFFFF8 (-8).
- REQ-035 A, B all ones: run with acc_in=0 then acc_in=1 -> all results 4, then 8.
- REQ-036 start_in held high for 20 cycles from IDLE -> first done_o at cycle 12; second start accepted only after DONE; no extra done_o pulse.
- REQ-037 reset asserted at FEED cycle 5 -> busy_o=0 immediately, no done_o, all 16 reads return 0; a following run yields the correct product.
- REQ-038 rd_addr=16 or 31 -> rd_data=0; read of address 0 during IDLE is stable over 10 cycles.
